// File: rtl/eth_pkt_gen_512.sv
// Synthetic Ethernet frame source for the 100G MAC TX AXI-Stream port; first beat appears one cycle after i_start.
// Beats hold stable while tready is low. Optional macro PKT_GEN_TIMESTAMP_EN puts a cycle-count stamp in bytes 18-21.
module eth_pkt_gen_512 #(
  parameter logic [47:0] P_DST_MAC  = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] P_SRC_MAC  = 48'h0000_0A35_0001,
  parameter logic [15:0] P_ETH_TYPE = 16'h88B5,
  parameter int unsigned P_MIN_LEN  = 60,
  parameter int unsigned P_MAX_LEN  = 9600
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic [15:0]  i_pkt_len,
  input  logic [31:0]  i_pkt_num,
  input  logic [7:0]   i_gap,
  output logic [511:0] o_axis_tdata,
  output logic [63:0]  o_axis_tkeep,
  output logic         o_axis_tvalid,
  output logic         o_axis_tlast,
  input  logic         i_axis_tready,
  output logic         o_busy,
  output logic [31:0]  o_tx_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP} state_t;

  localparam logic [15:0] MIN_L = 16'(P_MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(P_MAX_LEN);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [9:0]  last_beat_q, last_beat_d;
  logic [9:0]  beat_q, beat_d;
  logic [31:0] num_q, num_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic        stop_q, stop_d;

  logic [15:0] len_clamped;
  logic        hs, eof, count_done;

  assign len_clamped = (i_pkt_len < MIN_L) ? MIN_L :
                       (i_pkt_len > MAX_L) ? MAX_L : i_pkt_len;

  assign o_axis_tvalid = (state_q == S_DATA);
  assign o_axis_tlast  = o_axis_tvalid & (beat_q == last_beat_q);
  assign o_busy        = (state_q != S_IDLE);
  assign o_tx_cnt      = tx_cnt_q;

  assign hs         = o_axis_tvalid & i_axis_tready;
  assign eof        = hs & o_axis_tlast;
  assign count_done = (num_q != 32'd0) && ((tx_cnt_q + 32'd1) == num_q);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    num_d       = num_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    seq_d       = seq_q;
    tx_cnt_d    = tx_cnt_q;
    stop_d      = stop_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_DATA;
          len_d       = len_clamped;
          last_beat_d = 10'((len_clamped - 16'd1) >> 6);
          num_d       = i_pkt_num;
          gap_d       = i_gap;
          beat_d      = '0;
          seq_d       = '0;
          tx_cnt_d    = '0;
          stop_d      = 1'b0;
        end
      end
      S_DATA: begin
        if (i_stop) stop_d = 1'b1;
        if (hs) beat_d = beat_q + 10'd1;
        if (eof) begin
          beat_d = '0;
          seq_d  = seq_q + 32'd1;
          if (tx_cnt_q != '1) tx_cnt_d = tx_cnt_q + 32'd1;
          // A stop arriving together with the final handshake still wins.
          if (stop_q || i_stop || count_done) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else if (gap_q != 8'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
          end
        end
      end
      S_GAP: begin
        if (i_stop || stop_q) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end else if (gap_cnt_q == 8'd1) begin
          state_d = S_DATA;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      last_beat_q <= '0;
      beat_q      <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      seq_q       <= '0;
      tx_cnt_q    <= '0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_q       <= seq_d;
      tx_cnt_q    <= tx_cnt_d;
      stop_q      <= stop_d;
    end
  end

`ifdef PKT_GEN_TIMESTAMP_EN
  localparam int HDR_BYTES = 22;
  logic [31:0] ts_cnt_q, ts_q;
  logic [HDR_BYTES*8-1:0] hdr;

  // Stamp holds the counter value seen on the cycle the first beat is first presented.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (state_d == S_DATA && (state_q != S_DATA || eof)) ts_q <= ts_cnt_q + 32'd1;
    end
  end
  assign hdr = {P_DST_MAC, P_SRC_MAC, P_ETH_TYPE, seq_q, ts_q};
`else
  localparam int HDR_BYTES = 18;
  logic [HDR_BYTES*8-1:0] hdr;
  assign hdr = {P_DST_MAC, P_SRC_MAC, P_ETH_TYPE, seq_q};
`endif

  // Header bytes only ever fall in beat 0, so each lane picks from a fixed header slice.
  for (genvar g = 0; g < 64; g++) begin : g_byte
    logic [15:0] b;
    logic [7:0]  v;
    assign b = {beat_q, 6'(g)};
    if (g < HDR_BYTES) begin : g_hdr
      assign v = (beat_q == 10'd0) ? hdr[8*(HDR_BYTES-1-g) +: 8] : b[7:0];
    end else begin : g_pat
      assign v = b[7:0];
    end
    assign o_axis_tkeep[g]        = o_axis_tvalid & (b < len_q);
    assign o_axis_tdata[8*g +: 8] = o_axis_tkeep[g] ? v : 8'h00;
  end

endmodule

// File: tb/tb_eth_pkt_gen_512.sv
// Self-checking bench for eth_pkt_gen_512: randomised backpressure and configs against a byte-level frame model.
module tb_eth_pkt_gen_512;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start, i_stop;
  logic [15:0]  i_pkt_len;
  logic [31:0]  i_pkt_num;
  logic [7:0]   i_gap;
  logic [511:0] o_axis_tdata;
  logic [63:0]  o_axis_tkeep;
  logic         o_axis_tvalid, o_axis_tlast, i_axis_tready;
  logic         o_busy;
  logic [31:0]  o_tx_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  eth_pkt_gen_512 dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_pkt_len(i_pkt_len), .i_pkt_num(i_pkt_num), .i_gap(i_gap),
    .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep),
    .o_axis_tvalid(o_axis_tvalid), .o_axis_tlast(o_axis_tlast),
    .i_axis_tready(i_axis_tready), .o_busy(o_busy), .o_tx_cnt(o_tx_cnt)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int b, input logic [31:0] seq);
    logic [47:0] dst, src;
    logic [15:0] et;
    dst = 48'hFFFF_FFFF_FFFF;
    src = 48'h0000_0A35_0001;
    et  = 16'h88B5;
    if (b < 6)       return dst[8*(5-b) +: 8];
    else if (b < 12) return src[8*(11-b) +: 8];
    else if (b < 14) return et[8*(13-b) +: 8];
    else if (b < 18) return seq[8*(17-b) +: 8];
    else             return 8'(b % 256);
  endfunction

  // rdy_mode: 0 = always ready, 1 = toggle each cycle, 2 = random.
  task automatic run(input string name, input int len_in, input int num, input int gap,
                     input int rdy_mode, input int stop_frame, input int stop_beat,
                     input int exp_frames);
    int L, nb, k, frames, idle, sf;
    bit fin, extra_start;
    logic rdy;
    logic [511:0] ed;
    logic [63:0]  ek;
    L  = (len_in < 60) ? 60 : (len_in > 9600) ? 9600 : len_in;
    nb = (L + 63) / 64;
    sf = stop_frame;
    @(negedge clk);
    i_pkt_len = 16'(len_in); i_pkt_num = 32'(num); i_gap = 8'(gap); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({name, "/vld_after_start"}, 512'(o_axis_tvalid), 512'(1));
    k = 0; frames = 0; idle = 0; fin = 1'b0; extra_start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      i_start = 1'b0; i_stop = 1'b0;
      i_pkt_len = 16'($urandom); i_pkt_num = $urandom; i_gap = 8'($urandom);
      if (o_axis_tvalid) begin
        if (k == 0 && frames > 0) check({name, "/gap_cycles"}, 512'(idle), 512'(gap));
        ed = '0; ek = '0;
        for (int i = 0; i < 64; i++) begin
          if (k*64 + i < L) begin
            ed[8*i +: 8] = ref_byte(k*64 + i, 32'(frames));
            ek[i] = 1'b1;
          end
        end
        check({name, "/tdata"}, o_axis_tdata, ed);
        check({name, "/tkeep"}, 512'(o_axis_tkeep), 512'(ek));
        check({name, "/tlast"}, 512'(o_axis_tlast), 512'(k == nb-1));
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        i_axis_tready = rdy;
        if (frames == sf && k == stop_beat) begin
          i_stop = 1'b1;
          sf = -1;
        end
        if (!extra_start && k == 1) begin
          i_start = 1'b1;
          extra_start = 1'b1;
        end
        if (rdy) begin
          if (k == nb-1) begin
            frames++; k = 0; idle = 0;
          end else k++;
        end
      end else if (o_busy) begin
        idle++;
        i_axis_tready = 1'($urandom_range(0, 1));
      end else begin
        fin = 1'b1;
      end
    end
    check({name, "/timeout"}, 512'(fin), 512'(1));
    check({name, "/frames"}, 512'(frames), 512'(exp_frames));
    check({name, "/tx_cnt"}, 512'(o_tx_cnt), 512'(exp_frames));
    check({name, "/busy_end"}, 512'(o_busy), 512'(0));
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_axis_tready = 1'b1;
    i_pkt_len = '0; i_pkt_num = '0; i_gap = '0;
    #1;
    check("rst/tvalid", 512'(o_axis_tvalid), 512'(0));
    check("rst/tdata",  o_axis_tdata, 512'(0));
    check("rst/tkeep",  512'(o_axis_tkeep), 512'(0));
    check("rst/busy",   512'(o_busy), 512'(0));
    check("rst/tx_cnt", 512'(o_tx_cnt), 512'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run("len64",   64,    1, 0, 0, -1, 0, 1);
    run("len65",   65,    2, 0, 0, -1, 0, 2);
    run("len10",   10,    1, 0, 0, -1, 0, 1);
    run("len200",  200,   3, 4, 1, -1, 0, 3);
    run("stop",    200,   0, 0, 2,  4, 2, 5);
    run("stopgap", 130,   0, 3, 2,  1, 0, 2);
    run("lenmax",  10000, 1, 1, 2, -1, 0, 1);

    // Reset mid-frame in continuous mode.
    @(negedge clk);
    i_pkt_len = 16'd300; i_pkt_num = 32'd0; i_gap = 8'd0; i_start = 1'b1; i_axis_tready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    check("midrst/tx_cnt_before", 512'(o_tx_cnt), 512'(1));
    rst = 1'b1;
    #1;
    check("midrst/tvalid", 512'(o_axis_tvalid), 512'(0));
    check("midrst/tlast",  512'(o_axis_tlast), 512'(0));
    check("midrst/busy",   512'(o_busy), 512'(0));
    check("midrst/tx_cnt", 512'(o_tx_cnt), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", 100, 2, 0, 2, -1, 0, 2);

    for (int r = 0; r < 4; r++) begin
      int len_r, num_r, gap_r;
      len_r = $urandom_range(1, 700);
      num_r = $urandom_range(1, 3);
      gap_r = $urandom_range(0, 5);
      run($sformatf("rand%0d", r), len_r, num_r, gap_r, 2, -1, 0, num_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
